// File: rtl/pll_ctrl_pkg.sv
// Shared types and defaults for the PLL reconfiguration controller.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StShift,
        StUpdate,
        StWaitDone,
        StWaitLock
    } pll_rcfg_state_t;

    localparam int unsigned PLL_CHAIN_LEN_DEF   = 144;
    localparam int unsigned PLL_LOCK_STABLE_DEF = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for single-bit asynchronous inputs.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// Serial PLL scan-chain loader with configupdate, scandone wait and lock qualification.
// Optional PLL_RECONFIG_READBACK_EN captures the outgoing chain image into rd_data.
module pll_reconfig_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned CHAIN_LEN   = PLL_CHAIN_LEN_DEF,
    parameter int unsigned SCLK_DIV    = 4,
    parameter int unsigned LOCK_STABLE = PLL_LOCK_STABLE_DEF,
    parameter int unsigned TIMEOUT     = 65535
) (
    input  logic                 clk,
    input  logic                 areset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [CHAIN_LEN-1:0] req_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 pll_scanclk,
    output logic                 pll_scanclkena,
    output logic                 pll_scandata,
    output logic                 pll_configupdate,
    input  logic                 pll_scandone,
    input  logic                 pll_locked
`ifdef PLL_RECONFIG_READBACK_EN
    ,
    input  logic                 pll_scandataout,
    output logic [CHAIN_LEN-1:0] rd_data
`endif
);

    localparam int unsigned BitW = $clog2(CHAIN_LEN + 1);
    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
    localparam int unsigned StbW = $clog2(LOCK_STABLE + 1);
    localparam int unsigned PhW  = $clog2(2 * SCLK_DIV + 1);

    localparam logic [PhW-1:0]  PhRise  = PhW'(SCLK_DIV - 1);
    localparam logic [PhW-1:0]  PhLast  = PhW'(2 * SCLK_DIV - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(CHAIN_LEN);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT);
    localparam logic [StbW-1:0] StbLast = StbW'(LOCK_STABLE);

    pll_rcfg_state_t      state_q, state_d;
    logic [CHAIN_LEN-1:0] sh_q, sh_d;
    logic [BitW-1:0]      bits_q, bits_d;
    logic [PhW-1:0]       ph_q, ph_d;
    logic [TmoW-1:0]      tmo_q, tmo_d;
    logic [StbW-1:0]      stb_q, stb_d;
    logic                 sclk_q, sclk_d;
    logic                 sdata_q, sdata_d;
    logic                 sd_prev_q;
    logic                 scandone_s;
    logic                 locked_s;
`ifdef PLL_RECONFIG_READBACK_EN
    logic [CHAIN_LEN-1:0] rd_q, rd_d;
`endif

    sync_2ff u_sync_scandone (
        .clk_i  (clk),
        .rst_ni (areset_n),
        .d_i    (pll_scandone),
        .q_o    (scandone_s)
    );

    sync_2ff u_sync_locked (
        .clk_i  (clk),
        .rst_ni (areset_n),
        .d_i    (pll_locked),
        .q_o    (locked_s)
    );

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bits_d  = bits_q;
        ph_d    = ph_q;
        tmo_d   = tmo_q;
        stb_d   = stb_q;
        sclk_d  = sclk_q;
        sdata_d = sdata_q;
        done    = 1'b0;
        err     = 1'b0;
`ifdef PLL_RECONFIG_READBACK_EN
        rd_d    = rd_q;
`endif
        unique case (state_q)
            StIdle: begin
                ph_d = '0;
                if (req_valid) begin
                    sh_d    = req_data >> 1;
                    sdata_d = req_data[0];
                    bits_d  = '0;
                    sclk_d  = 1'b0;
                    state_d = StShift;
                end
            end
            StShift: begin
                ph_d = (ph_q == PhLast) ? '0 : ph_q + PhW'(1);
                if (ph_q == PhRise) begin
                    sclk_d = 1'b1;
                    if (bits_q != BitLast) bits_d = bits_q + BitW'(1);
`ifdef PLL_RECONFIG_READBACK_EN
                    rd_d = CHAIN_LEN'({pll_scandataout, rd_q} >> 1);
`endif
                end
                // Data advances only on the falling edge; the last fall ends the shift.
                if (ph_q == PhLast) begin
                    sclk_d = 1'b0;
                    if (bits_q == BitLast) begin
                        sdata_d = 1'b0;
                        state_d = StUpdate;
                    end else begin
                        sdata_d = sh_q[0];
                        sh_d    = sh_q >> 1;
                    end
                end
            end
            StUpdate: begin
                ph_d = ph_q + PhW'(1);
                if (ph_q == PhLast) begin
                    ph_d    = '0;
                    tmo_d   = '0;
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (scandone_s && !sd_prev_q) begin
                    tmo_d   = '0;
                    stb_d   = '0;
                    state_d = StWaitLock;
                end else if (tmo_q == TmoLast) begin
                    err     = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            StWaitLock: begin
                if (stb_q == StbLast) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end else if (tmo_q == TmoLast) begin
                    err     = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                    stb_d = locked_s ? stb_q + StbW'(1) : '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q   <= StIdle;
            sh_q      <= '0;
            bits_q    <= '0;
            ph_q      <= '0;
            tmo_q     <= '0;
            stb_q     <= '0;
            sclk_q    <= 1'b0;
            sdata_q   <= 1'b0;
            sd_prev_q <= 1'b0;
`ifdef PLL_RECONFIG_READBACK_EN
            rd_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            bits_q    <= bits_d;
            ph_q      <= ph_d;
            tmo_q     <= tmo_d;
            stb_q     <= stb_d;
            sclk_q    <= sclk_d;
            sdata_q   <= sdata_d;
            sd_prev_q <= scandone_s;
`ifdef PLL_RECONFIG_READBACK_EN
            rd_q      <= rd_d;
`endif
        end
    end

    assign req_ready        = (state_q == StIdle);
    assign busy             = ~req_ready;
    assign pll_scanclk      = sclk_q;
    assign pll_scandata     = sdata_q;
    assign pll_scanclkena   = (state_q == StShift);
    assign pll_configupdate = (state_q == StUpdate);
`ifdef PLL_RECONFIG_READBACK_EN
    assign rd_data          = rd_q;
`endif

endmodule
